// File: rtl/vr_arb_pkg.sv
// Shared constants and helpers for the valid/ready round-robin arbiter.
// The optional packet-lock feature in vr_rr_arbiter is enabled with ARB_PKT_LOCK_EN.
package vr_arb_pkg;

  localparam int unsigned MAX_NUM_REQ = 16;

  function automatic int unsigned next_idx(input int unsigned idx, input int unsigned n);
    return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first set request at or after ptr, modulo NUM_REQ.
// Uses a doubled request vector so the wrap-around search is a plain linear scan.
module rr_pick #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned IDX_WIDTH = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]   req,
  input  logic [IDX_WIDTH-1:0] ptr,
  output logic [NUM_REQ-1:0]   grant,
  output logic [IDX_WIDTH-1:0] idx,
  output logic                 any_valid
);

  localparam int unsigned PosW = $clog2(2 * NUM_REQ);

  logic [2*NUM_REQ-1:0] dbl;
  logic [PosW-1:0]      pos;

  assign dbl = {req, req};

  always_comb begin
    idx       = '0;
    any_valid = 1'b0;
    pos       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      pos = PosW'(ptr) + PosW'(k);
      if (!any_valid && dbl[pos]) begin
        any_valid = 1'b1;
        if (pos >= PosW'(NUM_REQ)) begin
          idx = IDX_WIDTH'(pos - PosW'(NUM_REQ));
        end else begin
          idx = IDX_WIDTH'(pos);
        end
      end
    end
    grant = '0;
    if (any_valid) begin
      grant[idx] = 1'b1;
    end
  end

endmodule

// File: rtl/vr_rr_arbiter.sv
// Round-robin arbiter sharing one registered valid/ready sink among NUM_REQ producers.
// Define ARB_PKT_LOCK_EN to hold the grant on one requester until its req_last beat.
module vr_rr_arbiter
  import vr_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned IDX_WIDTH  = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          out_valid,
  output logic [DATA_WIDTH-1:0]         out_data,
  input  logic                          out_ready,
  output logic [IDX_WIDTH-1:0]          out_src
);

  logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];
  logic [IDX_WIDTH-1:0]  ptr_q, ptr_d;
  logic [IDX_WIDTH-1:0]  pick_idx, win_idx;
  logic [NUM_REQ-1:0]    pick_grant_unused;
  logic                  pick_any, win_valid, can_load, hs;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign data_arr[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
  end

  rr_pick #(
    .NUM_REQ  (NUM_REQ),
    .IDX_WIDTH(IDX_WIDTH)
  ) u_pick (
    .req      (req_valid),
    .ptr      (ptr_q),
    .grant    (pick_grant_unused),
    .idx      (pick_idx),
    .any_valid(pick_any)
  );

`ifdef ARB_PKT_LOCK_EN
  logic                 lock_q, lock_d;
  logic [IDX_WIDTH-1:0] lock_idx_q, lock_idx_d;
`else
  logic unused_last;
  assign unused_last = ^req_last;
`endif

  always_comb begin
    can_load  = ~out_valid | out_ready;
    win_idx   = pick_idx;
    win_valid = pick_any;
`ifdef ARB_PKT_LOCK_EN
    // A locked requester owns the port even while its valid is low.
    if (lock_q) begin
      win_idx   = lock_idx_q;
      win_valid = 1'b1;
    end
`endif
    hs = win_valid & can_load & req_valid[win_idx];

    req_ready = '0;
    if (win_valid && can_load && reset) begin
      req_ready[win_idx] = 1'b1;
    end

    ptr_d = ptr_q;
`ifdef ARB_PKT_LOCK_EN
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    if (hs) begin
      if (req_last[win_idx]) begin
        lock_d = 1'b0;
        ptr_d  = IDX_WIDTH'(next_idx(32'(win_idx), NUM_REQ));
      end else begin
        lock_d     = 1'b1;
        lock_idx_d = win_idx;
      end
    end
`else
    if (hs) begin
      ptr_d = IDX_WIDTH'(next_idx(32'(win_idx), NUM_REQ));
    end
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
      ptr_q     <= '0;
    end else begin
      ptr_q <= ptr_d;
      if (can_load) begin
        out_valid <= hs;
        if (hs) begin
          out_data <= data_arr[win_idx];
          out_src  <= win_idx;
        end
      end
    end
  end

`ifdef ARB_PKT_LOCK_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
    end
  end
`endif

endmodule

// File: tb/tb_vr_rr_arbiter.sv
// Self-checking bench for vr_rr_arbiter: directed vector table, corner sequences
// and randomized traffic against a queue-free behavioural model.
module tb_vr_rr_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_last;
  logic [N-1:0]    req_ready;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic            out_ready;
  logic [1:0]      out_src;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vr_rr_arbiter #(
    .NUM_REQ   (N),
    .DATA_WIDTH(DW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req_valid(req_valid),
    .req_data (req_data),
    .req_last (req_last),
    .req_ready(req_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_ready(out_ready),
    .out_src  (out_src)
  );

  typedef struct {
    logic [N-1:0] valid;
    logic         ordy;
    logic [N-1:0] exp_ready;
    logic         exp_ov;
    logic [DW-1:0] exp_data;
    logic [1:0]   exp_src;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req_valid = '0;
    reset     = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    #1;
  endtask

  // Model state for the random phase
  int m_ptr;
  bit m_ov;
  logic [DW-1:0] m_data;
  int m_src;

  initial begin
    int g;
    bit can;
    logic [N-1:0] exp_rdy;

    reset     = 1'b0;
    req_valid = '1;
    req_data  = 32'h1312_1110;
    req_last  = '1;
    out_ready = 1'b1;
    #2;
    check("reset_out_valid", 32'(out_valid), 0);
    check("reset_out_data", 32'(out_data), 0);
    check("reset_out_src", 32'(out_src), 0);
    check("reset_req_ready", 32'(req_ready), 0);
    tick();
    reset = 1'b1;
    #1;

    // rotation, single requester, wrap, idle
    vecs[0]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 8'h10, 2'd0};
    vecs[1]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 8'h11, 2'd1};
    vecs[2]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 8'h12, 2'd2};
    vecs[3]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 8'h13, 2'd3};
    vecs[4]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 8'h10, 2'd0};
    vecs[5]  = '{4'b0100, 1'b1, 4'b0100, 1'b1, 8'h12, 2'd2};
    vecs[6]  = '{4'b0100, 1'b1, 4'b0100, 1'b1, 8'h12, 2'd2};
    vecs[7]  = '{4'b1001, 1'b1, 4'b1000, 1'b1, 8'h13, 2'd3};
    vecs[8]  = '{4'b1001, 1'b1, 4'b0001, 1'b1, 8'h10, 2'd0};
    vecs[9]  = '{4'b1001, 1'b1, 4'b1000, 1'b1, 8'h13, 2'd3};
    vecs[10] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 8'h00, 2'd0};

    for (int i = 0; i < 11; i++) begin
      req_valid = vecs[i].valid;
      out_ready = vecs[i].ordy;
      #1;
      check($sformatf("vec%0d_req_ready", i), 32'(req_ready), 32'(vecs[i].exp_ready));
      tick();
      check($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].exp_ov));
      if (vecs[i].exp_ov) begin
        check($sformatf("vec%0d_out_data", i), 32'(out_data), 32'(vecs[i].exp_data));
        check($sformatf("vec%0d_out_src", i), 32'(out_src), 32'(vecs[i].exp_src));
      end
    end

    // Reset mid-traffic: ptr is 1 before reset, must restart from 0
    req_valid = '1;
    out_ready = 1'b0;
    tick();
    check("pre_reset_out_valid", 32'(out_valid), 1);
    #2;
    reset = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 0);
    check("midrst_req_ready", 32'(req_ready), 0);
    check("midrst_out_data", 32'(out_data), 0);
    req_valid = 4'b1001;
    out_ready = 1'b1;
    tick();
    reset = 1'b1;
    #1;
    check("postrst_req_ready", 32'(req_ready), 32'b0001);
    tick();
    check("postrst_out_src", 32'(out_src), 0);
    check("postrst_out_data", 32'(out_data), 32'h10);

    // Stall: held beat stays, nobody gets ready, then drain+load on one edge
    req_valid = '1;
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      check("stall_req_ready", 32'(req_ready), 0);
      tick();
      check("stall_out_valid", 32'(out_valid), 1);
      check("stall_out_data", 32'(out_data), 32'h10);
      check("stall_out_src", 32'(out_src), 0);
    end
    out_ready = 1'b1;
    #1;
    check("unstall_req_ready", 32'(req_ready), 32'b0010);
    tick();
    check("unstall_out_valid", 32'(out_valid), 1);
    check("unstall_out_data", 32'(out_data), 32'h11);
    check("unstall_out_src", 32'(out_src), 1);

`ifdef ARB_PKT_LOCK_EN
    // Req 1 sends a 3-beat packet while 0 and 2 compete
    do_reset();
    req_data  = 32'h1312_1110;
    req_last  = 4'b0000;
    req_valid = 4'b0010;
    out_ready = 1'b1;
    #1;
    check("lock_b1_ready", 32'(req_ready), 32'b0010);
    tick();
    check("lock_b1_src", 32'(out_src), 1);
    req_valid = 4'b0111;
    #1;
    check("lock_b2_ready", 32'(req_ready), 32'b0010);
    tick();
    check("lock_b2_src", 32'(out_src), 1);
    req_last = 4'b0010;
    #1;
    check("lock_b3_ready", 32'(req_ready), 32'b0010);
    tick();
    check("lock_b3_src", 32'(out_src), 1);
    req_last = 4'b1111;
    #1;
    check("lock_next_ready", 32'(req_ready), 32'b0100);
    tick();
    check("lock_next_src", 32'(out_src), 2);
`endif

    // Randomized traffic against the behavioural model
    do_reset();
    req_last = '1;
    m_ptr  = 0;
    m_ov   = 1'b0;
    m_data = '0;
    m_src  = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      req_valid = N'($urandom);
      req_data  = $urandom;
      out_ready = ($urandom_range(3) != 0);
      #1;
      can = !m_ov || out_ready;
      g = -1;
      for (int k = 0; k < N; k++) begin
        if (g < 0 && req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      end
      exp_rdy = '0;
      if (g >= 0 && can) exp_rdy[g] = 1'b1;
      check("rnd_req_ready", 32'(req_ready), 32'(exp_rdy));
      if (can) begin
        if (g >= 0) begin
          m_ov   = 1'b1;
          m_data = req_data[g*DW +: DW];
          m_src  = g;
          m_ptr  = (g + 1) % N;
        end else begin
          m_ov = 1'b0;
        end
      end
      tick();
      check("rnd_out_valid", 32'(out_valid), 32'(m_ov));
      if (m_ov) begin
        check("rnd_out_data", 32'(out_data), 32'(m_data));
        check("rnd_out_src", 32'(out_src), 32'(m_src));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vr_rr_arbiter.md
Name: vr_rr_arbiter

Overview:
- N-input round-robin arbiter that shares one valid/ready sink (typically the write port of a FIFO) among several valid/ready producers.
- Output stage is registered: one data register plus a valid flag, giving full throughput with back-pressure.
- Sits between producer blocks and a shared FIFO `putBus`.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- DATA_WIDTH, 8, payload width per requester.
- IDX_WIDTH, $clog2(NUM_REQ), width of grant index (derived; do not override).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester valid.
- req_data  in  NUM_REQ*DATA_WIDTH  packed payloads; requester i at [i*DATA_WIDTH +: DATA_WIDTH].
- req_last  in  NUM_REQ  end-of-packet marker; used only with ARB_PKT_LOCK_EN, ignored otherwise.
- req_ready  out  NUM_REQ  per-requester ready; one-hot or zero.
- out_valid  out  1  registered output valid.
- out_data  out  DATA_WIDTH  registered output payload.
- out_ready  in  1  sink ready (e.g. FIFO putBus.ready).
- out_src  out  IDX_WIDTH  registered index of the requester whose beat is in out_data.

Behaviour:
- Reset (async, reset=0):
  - out_valid=0, out_data=0, out_src=0.
  - Priority pointer ptr=0; lock flag=0.
  - req_ready=0 while reset is asserted.
- Output register:
  - can_load = ~out_valid | out_ready.
  - On a clock edge with can_load=1 and any req_valid=1: register loads the winner's data and index, out_valid=1.
  - On a clock edge with can_load=1 and no req_valid: out_valid=0.
  - Latency: 1 cycle from input handshake to out_valid.
  - Throughput: 1 beat/cycle when out_ready stays high.
- Arbitration (combinational):
  - Winner g is the first i with req_valid[i]=1, searching ptr, ptr+1, …, ptr+NUM_REQ-1 modulo NUM_REQ.
  - req_ready[g] = can_load; all other req_ready = 0.
  - No requester sees ready without being the winner.
  - req_ready does not depend on its own req_valid beyond the winner selection.
- Pointer update:
  - On an accepted input beat (req_valid[g] & req_ready[g]), ptr <= (g+1) mod NUM_REQ.
  - Wraps from NUM_REQ-1 to 0.
  - No update when there is no handshake.
- Back-pressure: while out_valid=1 and out_ready=0:
  - out_data, out_src and out_valid hold.
  - All req_ready=0.
  - ptr holds.
- Simultaneous drain and load: out_ready=1 with a new winner replaces the register contents in the same edge with no bubble.
- Single active requester: granted every cycle.
- All active: strict rotation 0,1,…,N-1,0.
- A requester dropping valid before its handshake: allowed; arbitration re-evaluates the next cycle.

Optional Feature:
- Macro: ARB_PKT_LOCK_EN.
- With the macro defined:
  - After accepting a beat with req_last[g]=0, lock=1 and locked index L=g.
  - While locked, only L may be granted, even if L's valid is low; others are starved.
  - Accepting a beat from L with req_last=1 clears lock and sets ptr=(L+1) mod NUM_REQ.
  - During lock, ptr is not updated on beats with req_last=0.
  - reset clears lock.
- Without the macro: req_last is unconnected internally; every beat is arbitrated independently.

Decomposition:
- Package vr_arb_pkg:
  - Constant MAX_NUM_REQ=16.
  - Function next_idx(idx, n) implementing modulo increment.
- Sub-module rr_pick:
  - Purely combinational.
  - Inputs: req vector and ptr.
  - Outputs: one-hot grant, binary index and any_valid.
  - Implemented with a doubled-vector priority scan.

Test Plan:
- Reset mid-traffic: assert reset=0 with out_valid=1 -> out_valid=0, req_ready=0 immediately; after release, first grant goes to the lowest valid index from ptr=0.
- All 4 valid, out_ready=1, data = 0x10+i -> out_data sequence 0x10,0x11,0x12,0x13,0x10, one per cycle; out_src 0,1,2,3,0.
- Only req 2 valid, out_ready=1 -> req_ready[2]=1 every cycle; beats appear 1 cycle later; no bubbles.
- Stall: out_ready=0 for 5 cycles with out_valid=1 -> out_data stable and all req_ready=0; on release, the held beat drains and the next beat loads on the same edge.
- Wrap/fairness: ptr=3, req 0 and 3 valid -> grant 3, then 0, then 3.
- ARB_PKT_LOCK_EN: req 1 sends a 3-beat packet (last on beat 3) while req 0 and req 2 stay valid -> beats from req 1 are contiguous; next grant goes to 2.
